wb_unit: RTL and testbench

Write-back unit driving the register file write port (`RegWEn`, `rd_addr`, `rd_data`). Merges single-cycle ALU results with buffered long-latency (load/divide) results and guarantees at most one register write per cycle. Keeps a busy scoreboard of registers with outstanding long-latency writes so decode can stall on hazards. Sits between the execute/memory stages and the register file.

---
 rtl/rv_pkg.sv | 18 +
 rtl/wb_unit_if.sv | 39 +++
 rtl/wb_unit_fifo.sv | 68 ++++++
 rtl/wb_unit.sv | 132 +++++++++++++
 tb/tb_wb_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared core types for the write-back path: register file geometry and the
// {rd, data} request carried by the long-latency result queue.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Bundle of the write-back unit's pipeline-facing signals; the slave side is
// the write-back unit, the master side is execute/memory/decode.
interface wb_unit_if;
  import rv_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  alu_stall;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  iss_rd_busy;
  logic                  RegWEn;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           iss_valid, iss_rd, rs1_addr, rs2_addr,
    output alu_stall, mem_ready, rs1_busy, rs2_busy, iss_rd_busy,
           RegWEn, rd_addr, rd_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           iss_valid, iss_rd, rs1_addr, rs2_addr,
    input  alu_stall, mem_ready, rs1_busy, rs2_busy, iss_rd_busy,
           RegWEn, rd_addr, rd_data
  );

endinterface

// File: rtl/wb_unit_fifo.sv
// Synchronous queue of pending long-latency write-backs; pointers wrap
// naturally because DEPTH is a power of two.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_req_t                i_data,
  input  logic                   i_pop,
  output wb_req_t                o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t        r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == {CW{1'b0}});
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= {AW{1'b0}};
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
      r_wptr        <= r_wptr + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr <= {AW{1'b0}};
    end else if (w_pop) begin
      r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CW{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: merges ALU results with queued long-latency results onto a
// single register-file write port and keeps the busy scoreboard for decode.
module wb_unit
  import rv_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic     clk,
  input  logic     rst,
  wb_unit_if.slave io
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  logic                  w_alu_wr;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pending;
  logic [CW-1:0]         w_count;
  wb_req_t               w_head;
  wb_req_t               w_push_req;
  logic [NUM_REGS-1:0]   w_busy_set;
  logic [NUM_REGS-1:0]   w_busy_clr;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic                  w_wen_nxt;
  logic [REG_ADDR_W-1:0] w_rd_nxt;
  logic [XLEN-1:0]       w_data_nxt;
  logic [SW-1:0]         w_cnt_nxt;
  logic                  w_stall_nxt;

  logic                  r_wen;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;
  logic [NUM_REGS-1:0]   r_busy;
  logic [SW-1:0]         r_cnt;
  logic                  r_stall;

  // x0 results are discarded here; an x0 memory transfer still handshakes.
  assign w_alu_wr   = io.alu_valid && (io.alu_rd != {REG_ADDR_W{1'b0}});
  assign w_push     = io.mem_valid && !w_full && (io.mem_rd != {REG_ADDR_W{1'b0}});
  assign w_pop      = !w_alu_wr && !w_empty;
  assign w_pending  = (w_count != {CW{1'b0}});
  assign w_push_req = '{rd: io.mem_rd, data: io.mem_data};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (w_push_req),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  // A new issue to the register being retired keeps it busy (set beats clear).
  assign w_busy_set = (io.iss_valid && (io.iss_rd != {REG_ADDR_W{1'b0}}))
                    ? reg_onehot(io.iss_rd) : {NUM_REGS{1'b0}};
  assign w_busy_clr = w_pop ? reg_onehot(w_head.rd) : {NUM_REGS{1'b0}};
  assign w_busy_nxt = ((r_busy & ~w_busy_clr) | w_busy_set) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};

  assign io.mem_ready   = !w_full;
  assign io.alu_stall   = r_stall;
  assign io.rs1_busy    = r_busy[io.rs1_addr];
  assign io.rs2_busy    = r_busy[io.rs2_addr];
  assign io.iss_rd_busy = r_busy[io.iss_rd];
  assign io.RegWEn      = r_wen;
  assign io.rd_addr     = r_rd;
  assign io.rd_data     = r_data;

  always_comb begin
    w_wen_nxt  = 1'b0;
    w_rd_nxt   = {REG_ADDR_W{1'b0}};
    w_data_nxt = {XLEN{1'b0}};
    if (w_alu_wr) begin
      w_wen_nxt  = 1'b1;
      w_rd_nxt   = io.alu_rd;
      w_data_nxt = io.alu_data;
    end else if (w_pop) begin
      w_wen_nxt  = 1'b1;
      w_rd_nxt   = w_head.rd;
      w_data_nxt = w_head.data;
    end else begin
      w_wen_nxt  = 1'b0;
    end
  end

  // Count ALU wins that leave the queue waiting; the last one raises a one-cycle stall.
  always_comb begin
    w_cnt_nxt   = {SW{1'b0}};
    w_stall_nxt = 1'b0;
    if (w_alu_wr && w_pending) begin
      if (r_cnt == STARVE_LAST) begin
        w_cnt_nxt   = {SW{1'b0}};
        w_stall_nxt = 1'b1;
      end else begin
        w_cnt_nxt   = r_cnt + SW'(1);
        w_stall_nxt = 1'b0;
      end
    end else begin
      w_cnt_nxt   = {SW{1'b0}};
      w_stall_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_rd    <= {REG_ADDR_W{1'b0}};
      r_data  <= {XLEN{1'b0}};
      r_busy  <= {NUM_REGS{1'b0}};
      r_cnt   <= {SW{1'b0}};
      r_stall <= 1'b0;
    end else begin
      r_wen   <= w_wen_nxt;
      r_rd    <= w_rd_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stall <= w_stall_nxt;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_wb_unit;
  import rv_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_unit_if bus();

  wb_unit #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  wb_req_t     mq[$];
  logic [31:0] m_busy;
  int          m_cnt;
  logic        m_stall;
  logic        x_wen;
  logic [4:0]  x_rd;
  logic [31:0] x_data;
  logic        s_ready;
  logic        s_b1;

  typedef struct {
    logic        av; logic [4:0] ar; logic [31:0] ad;
    logic        mv; logic [4:0] mr; logic [31:0] md;
    logic        iv; logic [4:0] ir; logic [4:0]  rs1;
    logic        e_rdy; logic e_b1;
    logic        e_wen; logic [4:0] e_rd; logic [31:0] e_data;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic mv, input logic [4:0] mr, input logic [31:0] md,
    input logic iv, input logic [4:0] ir, input logic [4:0] rs1,
    input logic e_rdy, input logic e_b1,
    input logic e_wen, input logic [4:0] e_rd, input logic [31:0] e_data);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.iv = iv; v.ir = ir; v.rs1 = rs1; v.e_rdy = e_rdy; v.e_b1 = e_b1;
    v.e_wen = e_wen; v.e_rd = e_rd; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic mv, input logic [4:0] mr, input logic [31:0] md,
    input logic iv, input logic [4:0] ir, input logic [4:0] r1, input logic [4:0] r2);
    bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mr; bus.mem_data = md;
    bus.iss_valid = iv; bus.iss_rd = ir;
    bus.rs1_addr  = r1; bus.rs2_addr = r2;
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy  = 32'd0;
    m_cnt   = 0;
    m_stall = 1'b0;
  endtask

  // One clock: check lookups, advance the model, check the write port after the edge.
  task automatic cycle();
    logic    alu_wr, acc, pop, pending;
    wb_req_t h;
    #1;
    s_ready = bus.mem_ready;
    s_b1    = bus.rs1_busy;
    chk("mem_ready",   bus.mem_ready,   mq.size() < DEPTH);
    chk("alu_stall",   bus.alu_stall,   m_stall);
    chk("rs1_busy",    bus.rs1_busy,    m_busy[bus.rs1_addr]);
    chk("rs2_busy",    bus.rs2_busy,    m_busy[bus.rs2_addr]);
    chk("iss_rd_busy", bus.iss_rd_busy, m_busy[bus.iss_rd]);
    chk("alu_protocol", bus.alu_valid & m_stall, 1'b0);
    alu_wr  = bus.alu_valid && (bus.alu_rd != 5'd0);
    acc     = bus.mem_valid && (mq.size() < DEPTH);
    pending = (mq.size() != 0);
    pop     = !alu_wr && pending;
    x_wen = 1'b0; x_rd = 5'd0; x_data = 32'd0;
    if (alu_wr) begin
      x_wen = 1'b1; x_rd = bus.alu_rd; x_data = bus.alu_data;
    end else if (pop) begin
      h = mq.pop_front();
      x_wen = 1'b1; x_rd = h.rd; x_data = h.data;
      m_busy[h.rd] = 1'b0;
    end
    if (bus.iss_valid && bus.iss_rd != 5'd0) m_busy[bus.iss_rd] = 1'b1;
    m_busy[0] = 1'b0;
    m_stall = 1'b0;
    if (alu_wr && pending) begin
      m_cnt++;
      if (m_cnt == STARVE_MAX) begin
        m_cnt   = 0;
        m_stall = 1'b1;
      end
    end else begin
      m_cnt = 0;
    end
    if (acc && bus.mem_rd != 5'd0) mq.push_back('{rd: bus.mem_rd, data: bus.mem_data});
    @(posedge clk);
    #1;
    chk("RegWEn", bus.RegWEn, x_wen);
    if (x_wen) begin
      chk("rd_addr", bus.rd_addr, x_rd);
      chk("rd_data", bus.rd_data, x_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    model_reset();

    tbl[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    tbl[1]  = mk(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tbl[2]  = mk(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tbl[3]  = mk(1'b0, 5'd0, 32'd0,        1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    tbl[4]  = mk(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 32'h12345678);
    tbl[5]  = mk(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tbl[6]  = mk(1'b1, 5'd0, 32'd1,        1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tbl[7]  = mk(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tbl[8]  = mk(1'b1, 5'd4, 32'h44,       1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h44);
    tbl[9]  = mk(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33);
    tbl[10] = mk(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

    #12;
    chk("reset_RegWEn",    bus.RegWEn,    1'b0);
    chk("reset_rd_addr",   bus.rd_addr,   5'd0);
    chk("reset_rd_data",   bus.rd_data,   32'd0);
    chk("reset_alu_stall", bus.alu_stall, 1'b0);
    chk("reset_mem_ready", bus.mem_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md,
            tbl[i].iv, tbl[i].ir, tbl[i].rs1, 5'd0);
      cycle();
      chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_busy", i), s_b1, tbl[i].e_b1);
      chk($sformatf("tbl%0d_wen", i), bus.RegWEn, tbl[i].e_wen);
      if (tbl[i].e_wen) begin
        chk($sformatf("tbl%0d_rd", i), bus.rd_addr, tbl[i].e_rd);
        chk($sformatf("tbl%0d_data", i), bus.rd_data, tbl[i].e_data);
      end
    end

    // full queue under continuous ALU traffic, then forced drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(20 + i), 32'(32'hA0 + i), 1'b1, 5'(12 + i), 32'(32'hC0 + i),
            1'b0, 5'd0, 5'd0, 5'd0);
      cycle();
    end
    chk("full_ready", bus.mem_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(24 + i), 32'(32'hB0 + i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      cycle();
      chk($sformatf("starve%0d_stall", i), bus.alu_stall, (i == 4) ? 1'b1 : 1'b0);
      chk($sformatf("starve%0d_ready", i), bus.mem_ready, 1'b0);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle();
    chk("stall_cycle_ready", s_ready, 1'b0);
    chk("stall_pop_wen",     bus.RegWEn, 1'b1);
    chk("stall_pop_rd",      bus.rd_addr, 5'd12);
    chk("stall_pop_data",    bus.rd_data, 32'hC0);
    chk("stall_release",     bus.alu_stall, 1'b0);
    chk("ready_after_pop",   bus.mem_ready, 1'b1);
    for (int i = 0; i < 4; i++) cycle();

    // set/clear collision on rd=9
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd0);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    cycle();
    chk("collide_wen",  bus.RegWEn, 1'b1);
    chk("collide_rd",   bus.rd_addr, 5'd9);
    chk("collide_busy", bus.rs1_busy, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    cycle();
    cycle();

    // asynchronous reset with three queued entries and two busy registers
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd10, 5'd11);
    cycle();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA10, 1'b1, 5'd11, 5'd10, 5'd11);
    cycle();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd11, 32'hA11, 1'b0, 5'd0, 5'd10, 5'd11);
    cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA12, 1'b0, 5'd0, 5'd10, 5'd11);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd11);
    chk("pre_rst_full_q", bus.mem_ready, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_RegWEn",    bus.RegWEn,    1'b0);
    chk("arst_rd_addr",   bus.rd_addr,   5'd0);
    chk("arst_rd_data",   bus.rd_data,   32'd0);
    chk("arst_mem_ready", bus.mem_ready, 1'b1);
    chk("arst_alu_stall", bus.alu_stall, 1'b0);
    chk("arst_rs1_busy",  bus.rs1_busy,  1'b0);
    chk("arst_rs2_busy",  bus.rs2_busy,  1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // random traffic with varying ALU load against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic       av, mv, iv;
      logic [4:0] ir;
      int         load;
      load = 30 + 30 * ((i / 200) % 3);
      av   = !m_stall && ($urandom_range(0, 99) < load);
      mv   = ($urandom_range(0, 1) == 1);
      ir   = 5'($urandom_range(0, 31));
      iv   = !m_busy[ir] && ($urandom_range(0, 3) == 0);
      drive(av, 5'($urandom_range(0, 31)), $urandom, mv, 5'($urandom_range(0, 31)), $urandom,
            iv, ir, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
